logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit; successor to the fixed 1-bit two-to-five-input gate primitives.
- Applies one of eight selectable bitwise operations across WIDTH-bit operands.
- Also produces reduction flags (AND/OR/XOR across all result bits).
- Sits between operand-fetch and writeback in the core datapath, behind a valid/ready handshake with optional skid buffering.

Parameters:
- WIDTH, 8: operand and result width in bits (≥1).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_y  output  WIDTH  result.
- out_rand  output  1  AND-reduction of out_y.
- out_ror  output  1  OR-reduction of out_y; doubles as the non-zero flag.
- out_rxor  output  1  XOR-reduction of out_y (parity).
- op_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset: the clock and reset are fixed as one clock, clk; asynchronous active-low reset, reset_n.
  - reset_n low clears everything immediately, regardless of clk: out_valid=0, out_y=0, all flags=0, op_count=0, skid buffer empty.
  - in_ready=0 while reset_n is low. in_ready=1 from the first rising clk edge after release.
  - A beat in flight when reset asserts is discarded and not counted.
- Operation encoding, applied per bit:
  - 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR.
  - 110 NOT A (in_b ignored); 111 PASS A.
- Flags are computed from the result before registering and travel with it in the same beat.
- Input acceptance: a beat is accepted when in_valid & in_ready at a rising edge. Output transfer: a beat transfers when out_valid & out_ready.
- Latency: one cycle. A beat accepted at edge N is presented on out_* after edge N, provided the output stage is free.
- Output stability: while out_valid=1 and out_ready=0, out_y and all flags hold stable. out_valid never drops without a transfer.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Simultaneous accept and transfer in one cycle replaces the output register; full throughput.
- SKID=1:
  - Storage states: EMPTY (0 entries), ONE (output register valid), FULL (output plus skid entry).
  - in_ready is registered and equals (state != FULL).
  - EMPTY: accept → ONE.
  - ONE: accept without transfer → FULL (new beat into skid). Transfer without accept → EMPTY. Both → ONE with the new beat.
  - FULL: transfer → ONE (skid moves to output in the same edge). No accept is possible in FULL.
  - Order is strictly preserved; no beat is dropped or duplicated.
  - Full throughput whenever out_ready stays high.
- op_count:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W−1 to 0 with no saturation and no flag.
- Undefined op values cannot occur: all 3-bit codes are defined.
- WIDTH=1 must work. Reductions then equal out_y.

Decomposition:
- Shared package or header holds:
  - The op-code constants OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOTA, OP_PASSA, with 3-bit width constant OP_W.
  - The skid state encodings ST_EMPTY, ST_ONE, ST_FULL.
- One sub-module, logic_unit_core: purely combinational, parametrised by WIDTH.
  - Computes the result and the three reduction flags.
  - Instantiated once in logic_unit_pipe, ahead of the register/skid stage.

Test Plan:
1. Reset and idle, WIDTH=8:
   - Assert reset_n=0 mid-stream with a beat pending → out_valid=0, op_count=0, in_ready=0 immediately.
   - After release, in_ready=1 following the first edge.
2. Op sweep, out_ready=1, in_a=8'hA5, in_b=8'h3C, in_op=0..7 back to back. Required out_y sequence, one per cycle after a 1-cycle latency:
   - Results: 24, BD, 99, DB, 42, 66, 5A, A5.
   - out_rxor for these: 0, 0, 0, 0, 0, 0, 0, 0.
   - out_ror=1 for all; out_rand=0 for all.
3. Reduction edges:
   - AND of FF,FF → out_y=FF, rand=1, ror=1, rxor=0.
   - XOR of 5A,5A → out_y=00, rand=0, ror=0, rxor=0.
   - PASS A of 01 → rxor=1.
4. Backpressure, SKID=1:
   - Send 3 beats with out_ready=0 → first two accepted, in_ready=0 after the second.
   - out_y holds beat 1 stable.
   - Raise out_ready → beats emerge in order 1, 2, 3; op_count=3.
5. Simultaneous accept and transfer:
   - SKID=0 and SKID=1, with in_valid=out_ready=1 continuously for 20 beats → one result per cycle, no bubbles, op_count=20.
6. Counter wrap, CNT_W=4: 17 transfers → op_count sequence reaches 15, then 0, then 1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit.
//   OP_W / OP_*  : 3-bit operation select codes (all eight codes defined)
//   skid_state_e : occupancy of the output/skid storage
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

    // EMPTY: nothing held; ONE: output register valid; FULL: output + skid entry
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation plus reduction flags.
//   a, b    : WIDTH-bit operands
//   op      : operation select (OP_* codes)
//   y       : WIDTH-bit result
//   y_rand  : AND-reduction of y
//   y_ror   : OR-reduction of y (non-zero flag)
//   y_rxor  : XOR-reduction of y (parity)
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y,
    output logic             y_rand,
    output logic             y_ror,
    output logic             y_rxor
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

    assign y_rand = &y;
    assign y_ror  = |y;
    assign y_rxor = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit behind a valid/ready handshake.
//   clk, reset_n           : clock, asynchronous active-low reset
//   in_valid/in_ready      : operand beat handshake (in_a, in_b, in_op)
//   out_valid/out_ready    : result beat handshake (out_y + reduction flags)
//   op_count               : completed output handshakes, wraps silently
//   state_dbg              : storage occupancy for observation
// SKID=1 gives a two-entry buffer with registered in_ready; SKID=0 gives a
// single output register with combinational in_ready.
//
// Handshake: a beat moves on a rising edge where valid & ready are both 1.
// A producer holds its data stable while valid=1 and ready=0, and never
// withdraws valid without a transfer; out_* obey this towards the consumer.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_rand,
    output logic             out_ror,
    output logic             out_rxor,
    output logic [CNT_W-1:0] op_count,
    output skid_state_e      state_dbg
);

    localparam int BW = WIDTH + 3;   // result plus three flags per beat

    logic [WIDTH-1:0] core_y;
    logic             core_rand, core_ror, core_rxor;
    logic [BW-1:0]    res;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (in_a),
        .b      (in_b),
        .op     (in_op),
        .y      (core_y),
        .y_rand (core_rand),
        .y_ror  (core_ror),
        .y_rxor (core_rxor)
    );

    assign res = {core_y, core_rand, core_ror, core_rxor};

    skid_state_e      state_q, state_d;
    logic [BW-1:0]    out_q, skid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             acc, xfer;
    logic             load_out, load_skid, skid_to_out;

    assign out_valid = (state_q != ST_EMPTY);

    // in_ready_q is 0 in reset and 1 from the first edge after release in
    // both modes; without a skid entry it also gates on the output slot.
    assign in_ready = (SKID != 0) ? in_ready_q
                                  : (in_ready_q & (~out_valid | out_ready));

    assign acc  = in_valid & in_ready;
    assign xfer = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    load_out = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && xfer) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    // Only reachable with a skid entry: without one, acc in
                    // ONE implies out_ready and hence a transfer.
                    if (SKID != 0) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    skid_to_out = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (load_out) begin
                out_q <= res;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= res;
            end
            if (xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_y     = out_q[BW-1:3];
    assign out_rand  = out_q[2];
    assign out_ror   = out_q[1];
    assign out_rxor  = out_q[0];
    assign op_count  = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // shared stimulus
  logic       in_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;

  // dut_s1: SKID=1; dut_s0: SKID=0; dut_c4: CNT_W=4; dut_w1: WIDTH=1
  logic in_ready_s1, out_valid_s1, rand_s1, ror_s1, rxor_s1;
  logic [7:0] y_s1; logic [15:0] cnt_s1; skid_state_e st_s1;
  logic in_ready_s0, out_valid_s0, rand_s0, ror_s0, rxor_s0;
  logic [7:0] y_s0; logic [15:0] cnt_s0; skid_state_e st_s0;
  logic in_ready_c4, out_valid_c4, rand_c4, ror_c4, rxor_c4;
  logic [7:0] y_c4; logic [3:0] cnt_c4; skid_state_e st_c4;
  logic in_ready_w1, out_valid_w1, rand_w1, ror_w1, rxor_w1;
  logic [0:0] y_w1; logic [15:0] cnt_w1; skid_state_e st_w1;

  logic_unit_pipe #(.WIDTH(8), .SKID(1), .CNT_W(16)) dut_s1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_s1),
    .out_ready(out_ready), .out_y(y_s1), .out_rand(rand_s1), .out_ror(ror_s1),
    .out_rxor(rxor_s1), .op_count(cnt_s1), .state_dbg(st_s1));
  logic_unit_pipe #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut_s0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_s0),
    .out_ready(out_ready), .out_y(y_s0), .out_rand(rand_s0), .out_ror(ror_s0),
    .out_rxor(rxor_s0), .op_count(cnt_s0), .state_dbg(st_s0));
  logic_unit_pipe #(.WIDTH(8), .SKID(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_c4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_c4),
    .out_ready(out_ready), .out_y(y_c4), .out_rand(rand_c4), .out_ror(ror_c4),
    .out_rxor(rxor_c4), .op_count(cnt_c4), .state_dbg(st_c4));
  logic_unit_pipe #(.WIDTH(1), .SKID(1), .CNT_W(16)) dut_w1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w1),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_op(in_op), .out_valid(out_valid_w1),
    .out_ready(out_ready), .out_y(y_w1), .out_rand(rand_w1), .out_ror(ror_w1),
    .out_rxor(rxor_w1), .op_count(cnt_w1), .state_dbg(st_w1));

  int total = 0;
  int bad = 0;
  int sel = 0;  // which DUT's in_ready paces the driver
  logic in_ready_sel;
  assign in_ready_sel = (sel == 0) ? in_ready_s1 : (sel == 1) ? in_ready_s0 : in_ready_c4;

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_op8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [7:0] y;
    y = ref_op8(a, b, op);
    return {y, (y == 8'hFF), (y != 8'h00), ^y};
  endfunction

  function automatic logic [3:0] model1(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [7:0] y8;
    y8 = ref_op8(a, b, op);
    return {y8[0], y8[0], y8[0], y8[0]};
  endfunction

  // ---------------- scoreboards ----------------
  logic [10:0] exp_q_s1[$];
  logic [10:0] exp_q_s0[$];
  logic [3:0]  exp_q_w1[$];
  logic        hold_v_s1 = 1'b0, hold_v_s0 = 1'b0, hold_v_w1 = 1'b0;
  logic [10:0] hold_s1, hold_s0;
  logic [3:0]  hold_w1;

  always @(negedge clk) begin : mon_s1
    logic [10:0] obs, exp;
    obs = {y_s1, rand_s1, ror_s1, rxor_s1};
    if (!reset_n) begin
      exp_q_s1.delete();
      hold_v_s1 = 1'b0;
    end else begin
      if (in_valid && in_ready_s1) exp_q_s1.push_back(model8(in_a, in_b, in_op));
      if (hold_v_s1) begin
        total++;
        if (!out_valid_s1 || obs !== hold_s1) begin
          bad++;
          $display("FAIL s1_stall_hold: got v=%b %h required v=1 %h", out_valid_s1, obs, hold_s1);
        end
      end
      if (out_valid_s1 && out_ready) begin
        total++;
        if (exp_q_s1.size() == 0) begin
          bad++;
          $display("FAIL s1_unexpected_out: got %h required no beat", obs);
        end else begin
          exp = exp_q_s1.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL s1_result: got %h required %h", obs, exp);
          end
        end
      end
      hold_v_s1 = out_valid_s1 && !out_ready;
      hold_s1   = obs;
    end
  end

  always @(negedge clk) begin : mon_s0
    logic [10:0] obs, exp;
    obs = {y_s0, rand_s0, ror_s0, rxor_s0};
    if (!reset_n) begin
      exp_q_s0.delete();
      hold_v_s0 = 1'b0;
    end else begin
      if (in_valid && in_ready_s0) exp_q_s0.push_back(model8(in_a, in_b, in_op));
      if (hold_v_s0) begin
        total++;
        if (!out_valid_s0 || obs !== hold_s0) begin
          bad++;
          $display("FAIL s0_stall_hold: got v=%b %h required v=1 %h", out_valid_s0, obs, hold_s0);
        end
      end
      if (out_valid_s0 && out_ready) begin
        total++;
        if (exp_q_s0.size() == 0) begin
          bad++;
          $display("FAIL s0_unexpected_out: got %h required no beat", obs);
        end else begin
          exp = exp_q_s0.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL s0_result: got %h required %h", obs, exp);
          end
        end
      end
      hold_v_s0 = out_valid_s0 && !out_ready;
      hold_s0   = obs;
    end
  end

  always @(negedge clk) begin : mon_w1
    logic [3:0] obs, exp;
    obs = {y_w1, rand_w1, ror_w1, rxor_w1};
    if (!reset_n) begin
      exp_q_w1.delete();
      hold_v_w1 = 1'b0;
    end else begin
      if (in_valid && in_ready_w1) exp_q_w1.push_back(model1(in_a, in_b, in_op));
      if (hold_v_w1) begin
        total++;
        if (!out_valid_w1 || obs !== hold_w1) begin
          bad++;
          $display("FAIL w1_stall_hold: got v=%b %h required v=1 %h", out_valid_w1, obs, hold_w1);
        end
      end
      if (out_valid_w1 && out_ready) begin
        total++;
        if (exp_q_w1.size() == 0) begin
          bad++;
          $display("FAIL w1_unexpected_out: got %h required no beat", obs);
        end else begin
          exp = exp_q_w1.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL w1_result: got %h required %h", obs, exp);
          end
        end
      end
      hold_v_w1 = out_valid_w1 && !out_ready;
      hold_w1   = obs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // holds one beat until the selected DUT accepts it; leaves in_valid high
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int guard;
    logic acc;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready_sel;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 required accept within 100 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 0;
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({out_valid_s1, in_ready_s1, cnt_s1} !== 18'd0) begin
      bad++; $display("FAIL reset_idle_s1: got v=%b r=%b cnt=%0d required 0 0 0", out_valid_s1, in_ready_s1, cnt_s1);
    end
    total++;
    if ({out_valid_s0, in_ready_s0, cnt_s0} !== 18'd0) begin
      bad++; $display("FAIL reset_idle_s0: got v=%b r=%b cnt=%0d required 0 0 0", out_valid_s0, in_ready_s0, cnt_s0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (in_ready_s1 !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge: got %b required 0", in_ready_s1);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready_s1 !== 1'b1 || in_ready_s0 !== 1'b1) begin
      bad++; $display("FAIL ready_after_edge: got s1=%b s0=%b required 1 1", in_ready_s1, in_ready_s0);
    end
    // one completed transfer, then a beat left pending with another offered
    out_ready = 1'b1;
    send(8'h0F, 8'hF0, OP_OR);
    idle();
    repeat (2) @(posedge clk); #1;
    total++;
    if (cnt_s1 !== 16'd1) begin
      bad++; $display("FAIL count_one: got %0d required 1", cnt_s1);
    end
    out_ready = 1'b0;
    send(8'h81, 8'h00, OP_PASSA);
    in_a = 8'h42; in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid_s1, in_ready_s1, cnt_s1, y_s1, rand_s1, ror_s1, rxor_s1} !== 29'd0) begin
      bad++; $display("FAIL reset_midstream_s1: got v=%b r=%b cnt=%0d y=%h f=%b%b%b required all 0",
                      out_valid_s1, in_ready_s1, cnt_s1, y_s1, rand_s1, ror_s1, rxor_s1);
    end
    total++;
    if ({out_valid_s0, in_ready_s0, cnt_s0} !== 18'd0) begin
      bad++; $display("FAIL reset_midstream_s0: got v=%b r=%b cnt=%0d required 0 0 0", out_valid_s0, in_ready_s0, cnt_s0);
    end
    do_reset();
  endtask

  task automatic test_op_sweep();
    logic [7:0] tbl [8];
    tbl[0] = 8'h24; tbl[1] = 8'hBD; tbl[2] = 8'h99; tbl[3] = 8'hDB;
    tbl[4] = 8'h42; tbl[5] = 8'h66; tbl[6] = 8'h5A; tbl[7] = 8'hA5;
    sel = 0;
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) send(8'hA5, 8'h3C, 3'(k));
        idle();
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid_s1 && g < 10) begin @(negedge clk); g++; end
        for (int k = 0; k < 8; k++) begin
          total++;
          if ({out_valid_s1, y_s1, rand_s1, ror_s1, rxor_s1} !== {1'b1, tbl[k], 3'b010}) begin
            bad++; $display("FAIL sweep_s1 op%0d: got v=%b y=%h f=%b%b%b required v=1 y=%h f=010",
                            k, out_valid_s1, y_s1, rand_s1, ror_s1, rxor_s1, tbl[k]);
          end
          total++;
          if ({out_valid_s0, y_s0, rand_s0, ror_s0, rxor_s0} !== {1'b1, tbl[k], 3'b010}) begin
            bad++; $display("FAIL sweep_s0 op%0d: got v=%b y=%h f=%b%b%b required v=1 y=%h f=010",
                            k, out_valid_s0, y_s0, rand_s0, ror_s0, rxor_s0, tbl[k]);
          end
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_reductions();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic [2:0]  to [3];
    logic [10:0] te [3];
    ta[0] = 8'hFF; tb[0] = 8'hFF; to[0] = OP_AND;   te[0] = {8'hFF, 3'b110};
    ta[1] = 8'h5A; tb[1] = 8'h5A; to[1] = OP_XOR;   te[1] = {8'h00, 3'b000};
    ta[2] = 8'h01; tb[2] = 8'hEE; to[2] = OP_PASSA; te[2] = {8'h01, 3'b011};
    sel = 0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int g;
      send(ta[k], tb[k], to[k]);
      idle();
      g = 0;
      @(negedge clk);
      while (!out_valid_s1 && g < 10) begin @(negedge clk); g++; end
      total++;
      if ({y_s1, rand_s1, ror_s1, rxor_s1} !== te[k] || !out_valid_s1) begin
        bad++; $display("FAIL reduction%0d: got v=%b %h required v=1 %h", k, out_valid_s1,
                        {y_s1, rand_s1, ror_s1, rxor_s1}, te[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] order [3];
    order[0] = 8'h11; order[1] = 8'h22; order[2] = 8'hCC;
    sel = 0;
    do_reset();
    out_ready = 1'b0;
    send(8'h11, 8'h00, OP_PASSA);
    send(8'h22, 8'hFF, OP_AND);
    total++;
    if (in_ready_s1 !== 1'b0) begin
      bad++; $display("FAIL bp_ready_full: got %b required 0", in_ready_s1);
    end
    fork
      send(8'h33, 8'h00, OP_NOTA);
      begin
        int g;
        repeat (3) begin
          @(negedge clk);
          total++;
          if ({out_valid_s1, y_s1, in_ready_s1} !== {1'b1, 8'h11, 1'b0}) begin
            bad++; $display("FAIL bp_hold: got v=%b y=%h r=%b required 1 11 0", out_valid_s1, y_s1, in_ready_s1);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          g = 0;
          @(negedge clk);
          while (!out_valid_s1 && g < 10) begin @(negedge clk); g++; end
          total++;
          if (y_s1 !== order[k] || !out_valid_s1) begin
            bad++; $display("FAIL bp_order%0d: got v=%b y=%h required 1 %h", k, out_valid_s1, y_s1, order[k]);
          end
        end
      end
    join
    idle();
    @(posedge clk); #1;
    total++;
    if (cnt_s1 !== 16'd3) begin
      bad++; $display("FAIL bp_count: got %0d required 3", cnt_s1);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 20; k++)
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        idle();
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid_s1 && g < 10) begin @(negedge clk); g++; end
        for (int k = 0; k < 20; k++) begin
          total++;
          if (out_valid_s1 !== 1'b1 || out_valid_s0 !== 1'b1) begin
            bad++; $display("FAIL b2b_bubble beat%0d: got s1=%b s0=%b required 1 1", k, out_valid_s1, out_valid_s0);
          end
          if (k < 19) @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;
    total++;
    if (cnt_s1 !== 16'd20 || cnt_s0 !== 16'd20) begin
      bad++; $display("FAIL b2b_count: got s1=%0d s0=%0d required 20 20", cnt_s1, cnt_s0);
    end
  endtask

  task automatic test_counter_wrap();
    sel = 2;
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 17; k++) send(8'(k), 8'hF0, OP_XOR);
        idle();
      end
      begin
        for (int k = 1; k <= 17; k++) begin
          int g;
          logic [3:0] exp_cnt;
          exp_cnt = 4'(k);
          g = 0;
          @(negedge clk);
          while (!out_valid_c4 && g < 20) begin @(negedge clk); g++; end
          @(posedge clk); #1;
          total++;
          if (cnt_c4 !== exp_cnt) begin
            bad++; $display("FAIL wrap_count%0d: got %0d required %0d", k, cnt_c4, exp_cnt);
          end
        end
      end
    join
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_op_sweep();
    test_reductions();
    test_backpressure();
    test_back_to_back();
    test_counter_wrap();
    idle();
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    total++;
    if (exp_q_s1.size() != 0 || out_valid_s1 !== 1'b0) begin
      bad++; $display("FAIL drain_s1: got q=%0d v=%b required 0 0", exp_q_s1.size(), out_valid_s1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
